// File: rtl/ieee_adder_arbiter_if.sv
// Request, adder and response bus shared by the requesters, the adder and the
// round-robin adder arbiter. The arbiter sits on the slave side.
interface ieee_adder_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_add_sub;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                  adder_add_sub_bit;
    logic [31:0]           adder_inputA;
    logic [31:0]           adder_inputB;
    logic [31:0]           adder_outputC;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  halt_in;
    logic                  idle_out;

    modport slave (
        input  req_valid, req_add_sub, req_a, req_b, adder_outputC, halt_in,
        output req_ready, adder_add_sub_bit, adder_inputA, adder_inputB,
               rsp_valid, rsp_data, idle_out
    );

    modport master (
        output req_valid, req_add_sub, req_a, req_b, adder_outputC, halt_in,
        input  req_ready, adder_add_sub_bit, adder_inputA, adder_inputB,
               rsp_valid, rsp_data, idle_out
    );
endinterface

// File: rtl/ieee_adder_arbiter.sv
// Round-robin scheduler sharing one pipelined single-precision adder among
// NUM_REQ requesters; a tag pipeline routes each result back to its issuer.
//
// state  | meaning
// IDLE   | nothing in flight, no request seen; grants allowed unless halted
// ACTIVE | granting requests, results may be in flight
// DRAIN  | halt requested, no grants, waiting for in-flight results
// HALTED | halted with an empty pipeline, no grants
module ieee_adder_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 3
) (
    input  logic                clock_in,
    input  logic                reset_n,
    ieee_adder_arbiter_if.slave bus
);
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_DEPTH = ADDER_LATENCY + 1;
    localparam int CNT_W     = $clog2(ADDER_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t               state;
    state_t               stateNext;

    logic [PTR_W-1:0]     rrPtr;
    logic [PTR_W-1:0]     candIdx;
    logic [PTR_W-1:0]     grantIdx;
    logic                 grantAny;
    logic                 grantEnable;
    logic [NUM_REQ-1:0]   grantVec;
    logic [NUM_REQ-1:0]   readyVec;
    logic                 issue;
    logic                 retire;

    logic [31:0]          selA;
    logic [31:0]          selB;
    logic                 selSub;

    logic [31:0]          adderA;
    logic [31:0]          adderB;
    logic                 adderSub;

    logic [TAG_DEPTH-1:0] tagValid;
    logic [PTR_W-1:0]     tagIdx [TAG_DEPTH];
    logic [CNT_W-1:0]     inflight;

    logic [NUM_REQ-1:0]   rspValidReg;
    logic [31:0]          rspDataReg;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        candIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = PTR_W'((int'(rrPtr) + k) % NUM_REQ);
            if (!grantAny && bus.req_valid[candIdx]) begin
                grantAny = 1'b1;
                grantIdx = candIdx;
            end
        end
    end

    // Halt seen in IDLE blocks the grant so HALTED never holds an in-flight op.
    always_comb begin
        grantEnable = 1'b0;
        if (reset_n) begin
            grantEnable = (state == ACTIVE) || ((state == IDLE) && !bus.halt_in);
        end
    end

    always_comb begin
        grantVec = '0;
        if (grantAny) begin
            grantVec = NUM_REQ'(1) << grantIdx;
        end
        readyVec = grantEnable ? grantVec : '0;
        issue    = |readyVec;
        retire   = tagValid[TAG_DEPTH-1];
    end

    always_comb begin
        selA   = '0;
        selB   = '0;
        selSub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVec[i]) begin
                selA   = bus.req_a[i*32 +: 32];
                selB   = bus.req_b[i*32 +: 32];
                selSub = bus.req_add_sub[i];
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            adderA   <= '0;
            adderB   <= '0;
            adderSub <= 1'b0;
            rrPtr    <= PTR_W'(NUM_REQ - 1);
        end else if (issue) begin
            adderA   <= selA;
            adderB   <= selB;
            adderSub <= selSub;
            rrPtr    <= grantIdx;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            tagValid <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) begin
                tagIdx[s] <= '0;
            end
        end else begin
            tagValid[0] <= issue;
            tagIdx[0]   <= grantIdx;
            for (int s = 1; s < TAG_DEPTH; s++) begin
                tagValid[s] <= tagValid[s-1];
                tagIdx[s]   <= tagIdx[s-1];
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            rspValidReg <= '0;
            rspDataReg  <= '0;
        end else if (retire) begin
            rspValidReg <= NUM_REQ'(1) << tagIdx[TAG_DEPTH-1];
            rspDataReg  <= bus.adder_outputC;
        end else begin
            rspValidReg <= '0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (issue && !retire) begin
            inflight <= inflight + 1'b1;
        end else if (!issue && retire) begin
            inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.halt_in) begin
                    stateNext = HALTED;
                end else if (|bus.req_valid) begin
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.halt_in) begin
                    stateNext = ((inflight != '0) || issue) ? DRAIN : HALTED;
                end else if (!(|bus.req_valid) && (inflight == '0) && !issue) begin
                    stateNext = IDLE;
                end
            end
            DRAIN: begin
                if (!bus.halt_in) begin
                    stateNext = ACTIVE;
                end else if (inflight == '0) begin
                    stateNext = HALTED;
                end
            end
            HALTED: begin
                if (!bus.halt_in) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.req_ready         = readyVec;
    assign bus.adder_inputA      = adderA;
    assign bus.adder_inputB      = adderB;
    assign bus.adder_add_sub_bit = adderSub;
    assign bus.rsp_valid         = rspValidReg;
    assign bus.rsp_data          = rspDataReg;
    assign bus.idle_out          = (state == IDLE) || (state == HALTED);
endmodule

// File: tb/tb_ieee_adder_arbiter.sv
// Bench for ieee_adder_arbiter: behavioural pipelined float adder, per-requester
// operation queues, and a scoreboard of expected responses in issue order.
module tb_ieee_adder_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LAT     = 3;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        int          req;
        logic [31:0] res;
        int          cyc;
    } sb_t;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;

    ieee_adder_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    ieee_adder_arbiter #(.NUM_REQ(NUM_REQ), .ADDER_LATENCY(LAT)) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    int nCmp = 0;
    int nErr = 0;
    int cyc  = 0;

    vec_t opq [NUM_REQ][$];
    sb_t  sbq [$];
    int   grantLog [$];
    int   issueCyc [$];
    logic [NUM_REQ-1:0] hsVec = '0;
    logic [31:0] curRes [NUM_REQ];
    vec_t drvOp;
    sb_t  sbHead;
    int   monIdx;
    vec_t rrTbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input int r, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic [31:0] res);
        vec_t v;
        v.req = r; v.a = a; v.b = b; v.sub = s; v.res = res;
        return v;
    endfunction

    // Single <-> double conversion, exact for zero and normal numbers.
    function automatic logic [63:0] f2d(input logic [31:0] f);
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b, input logic s);
        real ra, rb, r;
        ra = $bitstoreal(f2d(a));
        rb = $bitstoreal(f2d(b));
        r  = s ? (ra - rb) : (ra + rb);
        return d2f($realtobits(r));
    endfunction

    logic [31:0] addPipe [LAT];
    always @(posedge clock_in) begin
        addPipe[0] <= fpAdd(bus.adder_inputA, bus.adder_inputB, bus.adder_add_sub_bit);
        for (int k = 1; k < LAT; k++) addPipe[k] <= addPipe[k-1];
    end
    assign bus.adder_outputC = addPipe[LAT-1];

    always @(posedge clock_in) cyc++;

    // Requester side: offer the next queued op once the current one is accepted.
    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_add_sub = '0;
        forever begin
            @(posedge clock_in);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!reset_n) begin
                    opq[i].delete();
                    bus.req_valid[i] = 1'b0;
                end else if (hsVec[i] || !bus.req_valid[i]) begin
                    if (opq[i].size() > 0) begin
                        drvOp = opq[i].pop_front();
                        bus.req_a[i*32 +: 32] = drvOp.a;
                        bus.req_b[i*32 +: 32] = drvOp.b;
                        bus.req_add_sub[i] = drvOp.sub;
                        curRes[i] = drvOp.res;
                        bus.req_valid[i] = 1'b1;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clock_in) begin
        hsVec = bus.req_valid & bus.req_ready;
        if (!reset_n) begin
            sbq.delete();
        end else begin
            chk("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
            if (hsVec != '0) begin
                chk("grant_onehot", $countones(hsVec), 32'd1);
                monIdx = 0;
                for (int i = 0; i < NUM_REQ; i++) if (hsVec[i]) monIdx = i;
                sbq.push_back('{req: monIdx, res: curRes[monIdx], cyc: cyc + 1});
                grantLog.push_back(monIdx);
                issueCyc.push_back(cyc + 1);
            end
            if (bus.rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b, required none in flight", bus.rsp_valid);
                end else begin
                    sbHead = sbq.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << sbHead.req));
                    chk("rsp_data", bus.rsp_data, sbHead.res);
                    chk("rsp_latency", cyc - sbHead.cyc, LAT + 1);
                end
            end
        end
    end

    function automatic int pendingOps();
        int n = 0;
        for (int i = 0; i < NUM_REQ; i++) n += opq[i].size();
        return n;
    endfunction

    task automatic step();
        @(posedge clock_in);
        #2;
    endtask

    task automatic waitQuiet(input string name);
        int n = 0;
        while ((pendingOps() != 0 || bus.req_valid != '0 || sbq.size() != 0) && n < 100) begin
            step();
            n++;
        end
        repeat (2) step();
        chk({name, "_done_in_budget"}, 32'(n >= 100), 32'd0);
    endtask

    task automatic waitGrants(input string name, input int target);
        int n = 0;
        while (grantLog.size() < target && n < 50) begin
            step();
            n++;
        end
        chk({name, "_grants_in_budget"}, 32'(n >= 50), 32'd0);
    endtask

    initial begin
        int gl;
        int ic;
        int t;
        int n;

        bus.halt_in = 1'b0;
        rrTbl[0] = mk(0, 32'h40400000, 32'h40800000, 1'b0, 32'h40E00000);
        rrTbl[1] = mk(1, 32'h41000000, 32'h40E00000, 1'b0, 32'h41700000);
        rrTbl[2] = mk(2, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        rrTbl[3] = mk(3, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
        rrTbl[4] = mk(0, 32'h40A00000, 32'h40000000, 1'b1, 32'h40400000);
        rrTbl[5] = mk(1, 32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000);
        rrTbl[6] = mk(2, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000);
        rrTbl[7] = mk(3, 32'h41200000, 32'h40800000, 1'b1, 32'h40C00000);

        repeat (3) step();
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_inputA", bus.adder_inputA, 32'd0);
        chk("reset_inputB", bus.adder_inputB, 32'd0);
        chk("reset_add_sub", 32'(bus.adder_add_sub_bit), 32'd0);
        chk("reset_idle", 32'(bus.idle_out), 32'd1);
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", 32'(bus.idle_out), 32'd1);

        // Round-robin with every requester continuously valid.
        gl = grantLog.size();
        ic = issueCyc.size();
        for (int i = 0; i < 8; i++) opq[rrTbl[i].req].push_back(rrTbl[i]);
        waitQuiet("round_robin");
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant_order", grantLog[gl + k], rrTbl[k].req);
            if (k > 0) chk("rr_issue_every_cycle", issueCyc[ic + k] - issueCyc[ic + k - 1], 32'd1);
        end

        // Single add from req0: granted in the cycle it is offered.
        opq[0].push_back(mk(0, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000));
        step();
        chk("single_ready_same_cycle", 32'(bus.req_ready), 32'b0001);
        waitQuiet("single_add");

        // Fairness: leave ptr on requester 1, then offer req0 and req3 together.
        opq[1].push_back(mk(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000));
        waitQuiet("set_ptr");
        gl = grantLog.size();
        opq[0].push_back(mk(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000));
        opq[3].push_back(mk(3, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000));
        waitQuiet("fairness");
        chk("fair_first_grant", grantLog[gl], 32'd3);
        chk("fair_second_grant", grantLog[gl + 1], 32'd0);

        // Zero operands pass straight through.
        opq[2].push_back(mk(2, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000));
        waitQuiet("zero_operands");

        // Halt after three issues; pending requests must not be granted while draining.
        gl = grantLog.size();
        for (int i = 0; i < 3; i++) opq[0].push_back(rrTbl[i + 4]);
        opq[0][0].req = 0; opq[0][1].req = 0; opq[0][2].req = 0;
        waitGrants("halt_issue", gl + 3);
        t = cyc;
        bus.halt_in = 1'b1;
        opq[1].push_back(mk(1, 32'h41000000, 32'h3F800000, 1'b0, 32'h41100000));
        opq[2].push_back(mk(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000));
        step();
        chk("drain_not_idle", 32'(bus.idle_out), 32'd0);
        n = 0;
        while (!bus.idle_out && n < 20) begin
            chk("drain_no_ready", 32'(bus.req_ready), 32'd0);
            step();
            n++;
        end
        chk("halt_idle_cycle", cyc - t, LAT + 2);
        chk("halt_results_delivered", sbq.size(), 32'd0);
        repeat (2) begin
            step();
            chk("halted_no_ready", 32'(bus.req_ready), 32'd0);
            chk("halted_idle", 32'(bus.idle_out), 32'd1);
        end
        chk("halt_grant_count", grantLog.size(), gl + 3);
        bus.halt_in = 1'b0;
        step();
        chk("release_idle_state", 32'(bus.idle_out), 32'd1);
        chk("release_grant_req1", 32'(bus.req_ready), 32'b0010);
        step();
        chk("release_active_state", 32'(bus.idle_out), 32'd0);
        waitQuiet("halt_release");

        // Reset with two ops in flight.
        gl = grantLog.size();
        opq[1].push_back(mk(1, 32'h40A00000, 32'h40000000, 1'b1, 32'h40400000));
        opq[1].push_back(mk(1, 32'h41200000, 32'h40800000, 1'b1, 32'h40C00000));
        waitGrants("reset_issue", gl + 2);
        reset_n = 1'b0;
        #1;
        chk("midreset_ready", 32'(bus.req_ready), 32'd0);
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset_rsp_data", bus.rsp_data, 32'd0);
        chk("midreset_inputA", bus.adder_inputA, 32'd0);
        chk("midreset_inputB", bus.adder_inputB, 32'd0);
        chk("midreset_add_sub", 32'(bus.adder_add_sub_bit), 32'd0);
        chk("midreset_idle", 32'(bus.idle_out), 32'd1);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (LAT + 3) begin
            step();
            chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        end
        gl = grantLog.size();
        for (int i = 0; i < NUM_REQ; i++) opq[i].push_back(rrTbl[i]);
        waitQuiet("post_reset");
        chk("post_reset_first_grant", grantLog[gl], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        nErr++;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $fatal(1, "watchdog");
    end
endmodule
